// File: rtl/mem_pkg.sv
// Shared opcodes, exception codes, FSM states and load/store decode for the MEM stage.
package mem_pkg;

  localparam int unsigned OP_CODE_W = 5;

  localparam logic [OP_CODE_W-1:0] OP_LW  = 5'b10100;
  localparam logic [OP_CODE_W-1:0] OP_SW  = 5'b10101;
  localparam logic [OP_CODE_W-1:0] OP_LB  = 5'b10110;
  localparam logic [OP_CODE_W-1:0] OP_LH  = 5'b10111;
  localparam logic [OP_CODE_W-1:0] OP_LBU = 5'b11000;
  localparam logic [OP_CODE_W-1:0] OP_LHU = 5'b11001;
  localparam logic [OP_CODE_W-1:0] OP_SB  = 5'b11010;
  localparam logic [OP_CODE_W-1:0] OP_SH  = 5'b11011;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    logic  is_store;
    logic  sign_ext;
    size_e size;
  } op_dec_t;

  // Classify an ALU opcode into access kind, size and extension mode.
  function automatic op_dec_t decode_op(input logic [OP_CODE_W-1:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin d.is_mem = 1'b1; d.is_load = 1'b1; end
      OP_SB, OP_SH, OP_SW:                 begin d.is_mem = 1'b1; d.is_store = 1'b1; end
      default: ;
    endcase
    case (op)
      OP_LB, OP_LBU, OP_SB: d.size = SZ_B;
      OP_LH, OP_LHU, OP_SH: d.size = SZ_H;
      default:              d.size = SZ_W;
    endcase
    d.sign_ext = (op == OP_LB) || (op == OP_LH);
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication + byte enables, load lane extraction + extension.
// Assumes DATA_W >= 16 so a halfword fits in a word.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NB    = DATA_W / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  op_dec_t             dec,
  input  logic [OFF_W-1:0]    off,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W-1:0]   ld_word,
  output logic [NB-1:0]       be_c,
  output logic [DATA_W-1:0]   st_lanes_c,
  output logic [DATA_W-1:0]   ld_data_c
);

  logic [DATA_W-1:0] lane;

  // Little-endian: the addressed byte lane moves down to bit 0.
  assign lane = ld_word >> {off, 3'b000};

  // Store data is replicated to every lane; BE picks the lanes actually written.
  always_comb begin
    be_c       = '1;
    st_lanes_c = st_data;
    case (dec.size)
      SZ_B: begin
        be_c       = NB'(1) << off;
        st_lanes_c = {NB{st_data[7:0]}};
      end
      SZ_H: begin
        be_c       = NB'(3) << {off[OFF_W-1:1], 1'b0};
        st_lanes_c = {(NB/2){st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load result with sign or zero extension.
  always_comb begin
    ld_data_c = lane;
    case (dec.size)
      SZ_B: ld_data_c = {{(DATA_W-8){dec.sign_ext & lane[7]}}, lane[7:0]};
      SZ_H: ld_data_c = {{(DATA_W-16){dec.sign_ext & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: load/store over a req/ack bus with timeout, pass-through for other ops.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned NB     = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Valid_i,
  output logic               Ready_o,
  output logic               Stall_o,
  input  logic [OP_W-1:0]    ALUop_i,
  input  logic               WriteReg_i,
  input  logic [RADDR_W-1:0] WriteDataAddr_i,
  input  logic [DATA_W-1:0]  WriteData_i,
  input  logic [ADDR_W-1:0]  MemAddr_i,
  input  logic [DATA_W-1:0]  Reg_i,
  output logic               MemCE_o,
  output logic               MemWE_o,
  output logic [NB-1:0]      MemBE_o,
  output logic [ADDR_W-1:0]  MemAddr_o,
  output logic [DATA_W-1:0]  MemData_o,
  input  logic [DATA_W-1:0]  MemData_i,
  input  logic               MemAck_i,
  output logic               Valid_o,
  output logic               WriteReg_o,
  output logic [RADDR_W-1:0] WriteDataAddr_o,
  output logic [DATA_W-1:0]  WriteData_o,
  output logic [1:0]         Exc_o
);

  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_dec_t            op_q, op_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic               wr_ok_q, wr_ok_d;

  logic               ready_d, ce_d, we_d, valid_d, wreg_d;
  logic [NB-1:0]      be_d;
  logic [ADDR_W-1:0]  maddr_d;
  logic [DATA_W-1:0]  mdata_d, wdata_d;
  logic [RADDR_W-1:0] wdaddr_d;
  logic [1:0]         exc_d;

  op_dec_t            dec_in, align_dec;
  logic [OFF_W-1:0]   align_off;
  logic               accept_c, misalign_c;
  logic [NB-1:0]      be_c;
  logic [DATA_W-1:0]  st_lanes_c, ld_data_c;

  assign dec_in   = decode_op(OP_CODE_W'(ALUop_i));
  assign accept_c = Valid_i & Ready_o;

  // The aligner sees the incoming op while idle and the captured op while waiting for ack.
  assign align_dec = (state_q == BUSY) ? op_q  : dec_in;
  assign align_off = (state_q == BUSY) ? off_q : MemAddr_i[OFF_W-1:0];

  // Halfwords need an even address, words need a word-aligned one.
  always_comb begin
    misalign_c = 1'b0;
    case (dec_in.size)
      SZ_H:    misalign_c = MemAddr_i[0];
      SZ_W:    misalign_c = |MemAddr_i[OFF_W-1:0];
      default: misalign_c = 1'b0;
    endcase
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .dec        (align_dec),
    .off        (align_off),
    .st_data    (Reg_i),
    .ld_word    (MemData_i),
    .be_c       (be_c),
    .st_lanes_c (st_lanes_c),
    .ld_data_c  (ld_data_c)
  );

  // Next-state and next-output logic; the bus request is held stable for the whole access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    off_d    = off_q;
    wr_ok_d  = wr_ok_q;
    ready_d  = Ready_o;
    ce_d     = MemCE_o;
    we_d     = MemWE_o;
    be_d     = MemBE_o;
    maddr_d  = MemAddr_o;
    mdata_d  = MemData_o;
    valid_d  = 1'b0;
    wreg_d   = 1'b0;
    wdaddr_d = WriteDataAddr_o;
    wdata_d  = WriteData_o;
    exc_d    = EXC_NONE;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          wdaddr_d = WriteDataAddr_i;
          op_d     = dec_in;
          off_d    = MemAddr_i[OFF_W-1:0];
          wr_ok_d  = WriteReg_i & (|WriteDataAddr_i);
          if (!dec_in.is_mem) begin
            valid_d = 1'b1;
            wreg_d  = WriteReg_i & (|WriteDataAddr_i);
            wdata_d = WriteData_i;
          end else if (misalign_c) begin
            valid_d = 1'b1;
            exc_d   = EXC_MISALIGN;
            wdata_d = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            ready_d = 1'b0;
            ce_d    = 1'b1;
            we_d    = dec_in.is_store;
            be_d    = be_c;
            maddr_d = {MemAddr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
            mdata_d = dec_in.is_store ? st_lanes_c : '0;
          end
        end
      end
      BUSY: begin
        if (MemAck_i || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d = IDLE;
          ready_d = 1'b1;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          maddr_d = '0;
          mdata_d = '0;
          valid_d = 1'b1;
          if (MemAck_i) begin
            wreg_d  = op_q.is_load & wr_ok_q;
            wdata_d = op_q.is_load ? ld_data_c : '0;
          end else begin
            exc_d   = EXC_TIMEOUT;
            wdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_q            <= '0;
      off_q           <= '0;
      wr_ok_q         <= 1'b0;
      Ready_o         <= 1'b1;
      Stall_o         <= 1'b0;
      MemCE_o         <= 1'b0;
      MemWE_o         <= 1'b0;
      MemBE_o         <= '0;
      MemAddr_o       <= '0;
      MemData_o       <= '0;
      Valid_o         <= 1'b0;
      WriteReg_o      <= 1'b0;
      WriteDataAddr_o <= '0;
      WriteData_o     <= '0;
      Exc_o           <= EXC_NONE;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      off_q           <= off_d;
      wr_ok_q         <= wr_ok_d;
      Ready_o         <= ready_d;
      Stall_o         <= ~ready_d;
      MemCE_o         <= ce_d;
      MemWE_o         <= we_d;
      MemBE_o         <= be_d;
      MemAddr_o       <= maddr_d;
      MemData_o       <= mdata_d;
      Valid_o         <= valid_d;
      WriteReg_o      <= wreg_d;
      WriteDataAddr_o <= wdaddr_d;
      WriteData_o     <= wdata_d;
      Exc_o           <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  localparam logic [4:0] LW  = 5'b10100;
  localparam logic [4:0] SW  = 5'b10101;
  localparam logic [4:0] LB  = 5'b10110;
  localparam logic [4:0] LH  = 5'b10111;
  localparam logic [4:0] LBU = 5'b11000;
  localparam logic [4:0] LHU = 5'b11001;
  localparam logic [4:0] SB  = 5'b11010;
  localparam logic [4:0] SH  = 5'b11011;
  localparam logic [4:0] ADD = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_i, Ready_o, Stall_o;
  logic [4:0]  ALUop_i;
  logic        WriteReg_i;
  logic [4:0]  WriteDataAddr_i;
  logic [31:0] WriteData_i, MemAddr_i, Reg_i;
  logic        MemCE_o, MemWE_o;
  logic [3:0]  MemBE_o;
  logic [31:0] MemAddr_o, MemData_o, MemData_i;
  logic        MemAck_i;
  logic        Valid_o, WriteReg_o;
  logic [4:0]  WriteDataAddr_o;
  logic [31:0] WriteData_o;
  logic [1:0]  Exc_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W(32), .ADDR_W(32), .RADDR_W(5), .OP_W(5), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .Valid_i(Valid_i), .Ready_o(Ready_o), .Stall_o(Stall_o),
    .ALUop_i(ALUop_i), .WriteReg_i(WriteReg_i), .WriteDataAddr_i(WriteDataAddr_i),
    .WriteData_i(WriteData_i), .MemAddr_i(MemAddr_i), .Reg_i(Reg_i),
    .MemCE_o(MemCE_o), .MemWE_o(MemWE_o), .MemBE_o(MemBE_o), .MemAddr_o(MemAddr_o),
    .MemData_o(MemData_o), .MemData_i(MemData_i), .MemAck_i(MemAck_i),
    .Valid_o(Valid_o), .WriteReg_o(WriteReg_o), .WriteDataAddr_o(WriteDataAddr_o),
    .WriteData_o(WriteData_o), .Exc_o(Exc_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from access size and address arithmetic.
  function automatic void model(input logic [4:0] op, input logic [31:0] addr,
                                input logic [31:0] regv, input logic [31:0] word,
                                output bit is_mem, output bit is_st, output bit mis,
                                output logic [3:0] be, output logic [31:0] sdata,
                                output logic [31:0] ldata);
    int     sz;
    bit     sgn;
    longint v, m;
    is_st  = op inside {SB, SH, SW};
    is_mem = is_st || (op inside {LB, LH, LW, LBU, LHU});
    sz     = (op inside {LB, LBU, SB}) ? 1 : (op inside {LH, LHU, SH}) ? 2 : 4;
    sgn    = op inside {LB, LH};
    mis    = is_mem && ((addr % sz) != 0);
    be     = 4'(((1 << sz) - 1) << (addr % 4));
    if (sz == 1)      sdata = (regv & 32'hFF) * 32'h01010101;
    else if (sz == 2) sdata = (regv & 32'hFFFF) * 32'h00010001;
    else              sdata = regv;
    m = (longint'(1) << (8 * sz)) - 1;
    v = (longint'(word) >> (8 * (addr % 4))) & m;
    if (sgn && v >= (m + 1) / 2) v = v - (m + 1);
    ldata = 32'(v);
  endfunction

  // One op from accept through result pulse, then an idle cycle with a stray ack.
  // ack_k: BUSY cycle (1-based) on which MemAck_i is raised; > TIMEOUT withholds it.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [4:0] rd,
                       input logic wr, input logic [31:0] wd, input logic [31:0] addr,
                       input logic [31:0] regv, input int ack_k, input logic [31:0] rdata);
    bit          is_mem, is_st, mis, ok;
    logic [3:0]  be;
    logic [31:0] sd, ld;
    int          ce_cycles, exp_ce;
    model(op, addr, regv, rdata, is_mem, is_st, mis, be, sd, ld);
    ok     = ack_k <= TIMEOUT;
    exp_ce = (is_mem && !mis) ? (ok ? ack_k : TIMEOUT) : 0;
    check({tag, "/ready_in"}, Ready_o, 1);
    Valid_i = 1'b1; ALUop_i = op; WriteReg_i = wr; WriteDataAddr_i = rd;
    WriteData_i = wd; MemAddr_i = addr; Reg_i = regv;
    tick();
    Valid_i = 1'b0; ALUop_i = 5'($urandom); WriteReg_i = 1'($urandom);
    WriteDataAddr_i = 5'($urandom); WriteData_i = $urandom; MemAddr_i = $urandom; Reg_i = $urandom;
    ce_cycles = 0;
    if (is_mem && !mis) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        check({tag, "/ce"}, MemCE_o, 1);
        check({tag, "/stall"}, Stall_o, 1);
        check({tag, "/ready_busy"}, Ready_o, 0);
        check({tag, "/valid_busy"}, Valid_o, 0);
        check({tag, "/we"}, MemWE_o, is_st);
        check({tag, "/be"}, MemBE_o, be);
        check({tag, "/maddr"}, MemAddr_o, addr & 32'hFFFF_FFFC);
        if (is_st) check({tag, "/mdata"}, MemData_o, sd);
        ce_cycles++;
        if (k == ack_k) begin MemAck_i = 1'b1; MemData_i = rdata; end
        tick();
        MemAck_i = 1'b0; MemData_i = $urandom;
        if (k == ack_k) break;
      end
    end
    check({tag, "/ce_cycles"}, 64'(ce_cycles), 64'(exp_ce));
    check({tag, "/valid"}, Valid_o, 1);
    check({tag, "/ce_done"}, MemCE_o, 0);
    check({tag, "/ready_done"}, Ready_o, 1);
    check({tag, "/stall_done"}, Stall_o, 0);
    check({tag, "/rd"}, WriteDataAddr_o, rd);
    check({tag, "/exc"}, Exc_o, mis ? 2'b01 : (is_mem && !ok) ? 2'b10 : 2'b00);
    check({tag, "/wreg"}, WriteReg_o,
          !mis && !is_st && wr && (rd != 0) && (!is_mem || ok));
    if (!is_mem) check({tag, "/wdata"}, WriteData_o, wd);
    else if (!is_st && !mis && ok) check({tag, "/ldata"}, WriteData_o, ld);
    MemAck_i = 1'($urandom);
    tick();
    MemAck_i = 1'b0;
    check({tag, "/pulse"}, Valid_o, 0);
    check({tag, "/ce_idle"}, MemCE_o, 0);
  endtask

  logic [4:0] ops [9];

  initial begin
    ops = '{LW, SW, LB, LH, LBU, LHU, SB, SH, ADD};
    rst = 1'b0; Valid_i = 1'b0; ALUop_i = '0; WriteReg_i = 1'b0; WriteDataAddr_i = '0;
    WriteData_i = '0; MemAddr_i = '0; Reg_i = '0; MemData_i = '0; MemAck_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", Ready_o, 1);
    check("rst/stall", Stall_o, 0);
    check("rst/ce", MemCE_o, 0);
    check("rst/valid", Valid_o, 0);
    check("rst/be", MemBE_o, 0);
    check("rst/wdata", WriteData_o, 0);
    check("rst/exc", Exc_o, 0);
    rst = 1'b1;
    tick();

    do_op("lw_ack3", LW, 5'd5, 1'b1, 32'h0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    check("lw_ack3/value", WriteData_o, 32'hDEADBEEF);
    do_op("sb_203", SB, 5'd6, 1'b1, 32'h0, 32'h203, 32'h0000_00A5, 1, 32'h0);
    do_op("lb_2", LB, 5'd7, 1'b1, 32'h0, 32'h2, 32'h0, 2, 32'h0080FF00);
    do_op("lbu_2", LBU, 5'd8, 1'b1, 32'h0, 32'h2, 32'h0, 1, 32'h0080FF00);
    do_op("lh_mis", LH, 5'd9, 1'b1, 32'h0, 32'h101, 32'h0, 1, 32'h0);
    do_op("sw_mis", SW, 5'd9, 1'b0, 32'h0, 32'h102, 32'h1, 1, 32'h0);
    do_op("sh_102", SH, 5'd3, 1'b1, 32'h0, 32'h102, 32'h1234BEEF, 2, 32'h0);
    do_op("lh_neg", LH, 5'd4, 1'b1, 32'h0, 32'h206, 32'h0, 2, 32'h8001_7FFF);
    do_op("lw_tmo", LW, 5'd10, 1'b1, 32'h0, 32'h100, 32'h0, TIMEOUT + 1, 32'h0);
    do_op("lw_ack15", LW, 5'd10, 1'b1, 32'h0, 32'h100, 32'h0, TIMEOUT, 32'h1234_5678);
    do_op("add_rd0", ADD, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0, 1, 32'h0);
    do_op("add_rd7", ADD, 5'd7, 1'b1, 32'h0BAD_CAFE, 32'h0, 32'h0, 1, 32'h0);

    // Reset in the middle of an access.
    check("mid_rst/ready_in", Ready_o, 1);
    Valid_i = 1'b1; ALUop_i = LW; MemAddr_i = 32'h300; WriteReg_i = 1'b1; WriteDataAddr_i = 5'd3;
    tick();
    Valid_i = 1'b0;
    tick();
    check("mid_rst/ce_before", MemCE_o, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst/ce", MemCE_o, 0);
    check("mid_rst/ready", Ready_o, 1);
    check("mid_rst/stall", Stall_o, 0);
    check("mid_rst/be", MemBE_o, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    MemAck_i = 1'b1; MemData_i = 32'hFFFF_FFFF;
    tick();
    MemAck_i = 1'b0;
    check("late_ack/valid", Valid_o, 0);
    check("late_ack/ce", MemCE_o, 0);
    do_op("post_rst_add", ADD, 5'd11, 1'b1, 32'h1357_9BDF, 32'h0, 32'h0, 1, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      int          ak;
      op = ops[$urandom_range(0, 8)];
      ak = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(1, TIMEOUT + 1);
      do_op($sformatf("rnd%0d", i), op, 5'($urandom), 1'($urandom), $urandom,
            $urandom, $urandom, ak, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
